// File: rtl/usb3_if_pkg.sv
`default_nettype none
// ============================================================================
// usb3_if_pkg : shared types and constants for the FT60x receive interface
// Revision    : 1.0
// ============================================================================
package usb3_if_pkg;

  localparam int DATA_W     = 32;
  localparam int SKID_DEPTH = 2;
  localparam int CNT_W      = $clog2(SKID_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    READ = 2'd2
  } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/usb3_rx_skid.sv
`default_nettype none
// ============================================================================
// usb3_rx_skid : 2-entry in-order skid buffer between bridge bus and FIFO
// Revision     : 1.0
// ============================================================================
module usb3_rx_skid
  import usb3_if_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  cnt,
  output logic [CNT_W-1:0]  cnt_n
);

  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              do_pop, do_push;

  always_comb begin
    do_pop  = pop && (cnt_q != '0);
    do_push = push && ((cnt_q != CNT_W'(SKID_DEPTH)) || do_pop);
    cnt_d   = cnt_q;
    head_d  = head_q;
    tail_d  = tail_q;

    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    // The head only moves when a second entry exists behind it; otherwise it
    // keeps its last value so the FIFO data bus stays quiet while empty.
    if (do_pop && (cnt_q == CNT_W'(2))) begin
      head_d = tail_q;
    end

    if (do_push) begin
      if ((cnt_q == '0) || (do_pop && (cnt_q == CNT_W'(1)))) begin
        head_d = din;
      end else begin
        tail_d = din;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head  = head_q;
  assign cnt   = cnt_q;
  assign cnt_n = cnt_d;

endmodule
`default_nettype wire

// File: rtl/usb3_if_rx.sv
`default_nettype none
// ============================================================================
// usb3_if_rx : FT60x 245 sync-FIFO receive side into the dc32 FIFO
// Revision   : 1.0
// ============================================================================
module usb3_if_rx
  import usb3_if_pkg::*;
(
  input  logic              ftdi_clk,
  input  logic              reset_n,
  input  logic              FR_RXF,
  output logic              FT_OE,
  output logic              FT_RD,
  input  logic [DATA_W-1:0] usb3_data_in,
  output logic              write_to_dc32_fifo,
  output logic [DATA_W-1:0] dc32_fifo_data_in,
  input  logic              dc32_fifo_is_full
);

  rx_state_e         state_q, state_d;
  logic              ft_oe_q, ft_oe_d;
  logic              ft_rd_q, ft_rd_d;
  logic              push, pop;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [DATA_W-1:0] head;

  // A word is on the bus whenever the bridge has data and our read strobe is active.
  assign push = !ft_rd_q && !FR_RXF;
  assign pop  = (cnt != '0) && !dc32_fifo_is_full;

  usb3_rx_skid u_skid (
    .clk   (ftdi_clk),
    .rst_n (reset_n),
    .push  (push),
    .pop   (pop),
    .din   (usb3_data_in),
    .head  (head),
    .cnt   (cnt),
    .cnt_n (cnt_n)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!FR_RXF && (cnt_n == '0)) state_d = TURN;
      end
      TURN: begin
        if (FR_RXF)                         state_d = IDLE;
        else if (cnt_n <= CNT_W'(1))        state_d = READ;
      end
      READ: begin
        if (FR_RXF || (cnt_n == CNT_W'(SKID_DEPTH))) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ft_oe_d = (state_d == IDLE);
    ft_rd_d = (state_d != READ);
  end

  always_ff @(posedge ftdi_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ft_oe_q <= 1'b1;
      ft_rd_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ft_oe_q <= ft_oe_d;
      ft_rd_q <= ft_rd_d;
    end
  end

  assign FT_OE              = ft_oe_q;
  assign FT_RD              = ft_rd_q;
  assign write_to_dc32_fifo = pop;
  assign dc32_fifo_data_in  = head;

endmodule
`default_nettype wire

// File: tb/tb_usb3_if_rx.sv
`default_nettype none
// ============================================================================
// tb_usb3_if_rx : bridge model plus scoreboard checking usb3_if_rx
// Revision      : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_usb3_if_rx;

  logic        ftdi_clk = 1'b0;
  logic        reset_n;
  logic        FR_RXF;
  logic        FT_OE, FT_RD;
  logic [31:0] usb3_data_in;
  logic        write_to_dc32_fifo;
  logic [31:0] dc32_fifo_data_in;
  logic        dc32_fifo_is_full;
  logic [31:0] bridge_word;

  int n_assert = 0;
  int n_fail   = 0;
  int n_writes = 0;
  int n_pushes = 0;
  bit mon_en   = 0;
  logic [31:0] sb_q[$];

  assign usb3_data_in = bridge_word;

  always #5 ftdi_clk = ~ftdi_clk;

  usb3_if_rx dut (
    .ftdi_clk           (ftdi_clk),
    .reset_n            (reset_n),
    .FR_RXF             (FR_RXF),
    .FT_OE              (FT_OE),
    .FT_RD              (FT_RD),
    .usb3_data_in       (usb3_data_in),
    .write_to_dc32_fifo (write_to_dc32_fifo),
    .dc32_fifo_data_in  (dc32_fifo_data_in),
    .dc32_fifo_is_full  (dc32_fifo_is_full)
  );

  // Bridge + scoreboard: observe at the falling edge, commit after the rising edge.
  initial begin : monitor
    bit          have_exp;
    logic        exp_oe, exp_rd, exp_wr, do_push, do_pop;
    int          sz_n;
    logic [31:0] push_data;
    have_exp = 0;
    forever begin
      @(negedge ftdi_clk);
      if (!reset_n || !mon_en) begin
        sb_q.delete();
        have_exp = 0;
        continue;
      end
      if (have_exp) begin
        n_assert++;
        if (FT_OE !== exp_oe || FT_RD !== exp_rd) begin
          n_fail++;
          $display("FAIL strobes: got OE=%b RD=%b expected OE=%b RD=%b at %0t", FT_OE, FT_RD, exp_oe, exp_rd, $time);
        end
      end
      n_assert++;
      if (FT_OE === 1'b1 && FT_RD === 1'b0) begin
        n_fail++;
        $display("FAIL strobe_legal: RD active with OE released at %0t", $time);
      end
      exp_wr = (sb_q.size() != 0) && !dc32_fifo_is_full;
      n_assert++;
      if (write_to_dc32_fifo !== exp_wr) begin
        n_fail++;
        $display("FAIL write_en: got %b expected %b at %0t", write_to_dc32_fifo, exp_wr, $time);
      end
      if (sb_q.size() != 0) begin
        n_assert++;
        if (dc32_fifo_data_in !== sb_q[0]) begin
          n_fail++;
          $display("FAIL fifo_data: got %h expected %h at %0t", dc32_fifo_data_in, sb_q[0], $time);
        end
      end
      n_assert++;
      if (int'(dut.cnt) != sb_q.size()) begin
        n_fail++;
        $display("FAIL occupancy: got %0d expected %0d at %0t", dut.cnt, sb_q.size(), $time);
      end
      do_push = (FT_RD === 1'b0) && (FR_RXF === 1'b0);
      do_pop  = exp_wr;
      sz_n    = sb_q.size() + int'(do_push) - int'(do_pop);
      n_assert++;
      if (sz_n > 2) begin
        n_fail++;
        $display("FAIL overflow: got occupancy %0d expected at most 2 at %0t", sz_n, $time);
      end
      if (FT_OE && FT_RD) begin
        exp_oe = !(!FR_RXF && sz_n == 0);
        exp_rd = 1'b1;
      end else if (FT_RD) begin
        if (FR_RXF)          begin exp_oe = 1'b1; exp_rd = 1'b1; end
        else if (sz_n <= 1)  begin exp_oe = 1'b0; exp_rd = 1'b0; end
        else                 begin exp_oe = 1'b0; exp_rd = 1'b1; end
      end else begin
        if (FR_RXF || sz_n == 2) begin exp_oe = 1'b1; exp_rd = 1'b1; end
        else                     begin exp_oe = 1'b0; exp_rd = 1'b0; end
      end
      have_exp  = 1;
      push_data = bridge_word;
      @(posedge ftdi_clk);
      #1;
      if (!reset_n) begin
        sb_q.delete();
        have_exp = 0;
        continue;
      end
      if (do_pop) begin
        void'(sb_q.pop_front());
        n_writes++;
      end
      if (do_push) begin
        sb_q.push_back(push_data);
        bridge_word = bridge_word + 32'd1;
        n_pushes++;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge ftdi_clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset_n           = 1'b0;
    FR_RXF            = 1'b0;
    dc32_fifo_is_full = 1'b0;
    bridge_word       = 32'hDEAD_0000;
    repeat (4) begin
      @(negedge ftdi_clk);
      n_assert++;
      if ({FT_OE, FT_RD, write_to_dc32_fifo} !== 3'b110) begin
        n_fail++;
        $display("FAIL reset_strobes: got OE/RD/WR=%b%b%b expected 110", FT_OE, FT_RD, write_to_dc32_fifo);
      end
      n_assert++;
      if (dc32_fifo_data_in !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_data: got %h expected 0", dc32_fifo_data_in);
      end
    end
    FR_RXF = 1'b1;
    @(posedge ftdi_clk);
    #3;
    reset_n = 1'b1;
    tick(2);
    mon_en = 1;
    n_assert++;
    if ({FT_OE, FT_RD} !== 2'b11) begin
      n_fail++;
      $display("FAIL post_reset_idle: got OE/RD=%b%b expected 11", FT_OE, FT_RD);
    end
  endtask

  task automatic test_burst();
    int w0;
    bridge_word = 32'h1000_0000;
    w0          = n_writes;
    FR_RXF      = 1'b0;
    @(negedge ftdi_clk);
    n_assert++;
    if (FT_OE !== 1'b1) begin
      n_fail++;
      $display("FAIL burst_oe_early: got OE=%b expected 1", FT_OE);
    end
    tick();
    n_assert++;
    if ({FT_OE, FT_RD} !== 2'b01) begin
      n_fail++;
      $display("FAIL burst_turn: got OE/RD=%b%b expected 01", FT_OE, FT_RD);
    end
    tick();
    n_assert++;
    if ({FT_OE, FT_RD} !== 2'b00) begin
      n_fail++;
      $display("FAIL burst_read: got OE/RD=%b%b expected 00", FT_OE, FT_RD);
    end
    tick();
    for (int i = 0; i < 8; i++) begin
      @(negedge ftdi_clk);
      n_assert++;
      if (write_to_dc32_fifo !== 1'b1 || dc32_fifo_data_in !== 32'h1000_0000 + 32'(i)) begin
        n_fail++;
        $display("FAIL burst_word%0d: got wr=%b data=%h expected wr=1 data=%h", i, write_to_dc32_fifo, dc32_fifo_data_in, 32'h1000_0000 + 32'(i));
      end
      @(posedge ftdi_clk);
      #1;
      if (i == 6) FR_RXF = 1'b1;
    end
    n_assert++;
    if ({FT_OE, FT_RD, write_to_dc32_fifo} !== 3'b110) begin
      n_fail++;
      $display("FAIL burst_end: got OE/RD/WR=%b%b%b expected 110", FT_OE, FT_RD, write_to_dc32_fifo);
    end
    tick(3);
    n_assert++;
    if (n_writes - w0 != 8) begin
      n_fail++;
      $display("FAIL burst_count: got %0d writes expected 8", n_writes - w0);
    end
  endtask

  task automatic test_rxf_stop();
    int          w0;
    logic [31:0] base;
    w0     = n_writes;
    base   = bridge_word;
    FR_RXF = 1'b0;
    tick(5);
    FR_RXF = 1'b1;
    tick();
    n_assert++;
    if ({FT_OE, FT_RD} !== 2'b11) begin
      n_fail++;
      $display("FAIL rxf_release: got OE/RD=%b%b expected 11", FT_OE, FT_RD);
    end
    tick(3);
    n_assert++;
    if (n_writes - w0 != 3 || bridge_word - base != 32'd3) begin
      n_fail++;
      $display("FAIL rxf_count: got %0d writes %0d reads expected 3 and 3", n_writes - w0, bridge_word - base);
    end
    FR_RXF = 1'b0;
    tick();
    n_assert++;
    if ({FT_OE, FT_RD} !== 2'b01) begin
      n_fail++;
      $display("FAIL rxf_restart_turn: got OE/RD=%b%b expected 01", FT_OE, FT_RD);
    end
    tick();
    n_assert++;
    if (FT_RD !== 1'b0) begin
      n_fail++;
      $display("FAIL rxf_restart_read: got RD=%b expected 0", FT_RD);
    end
    tick(4);
    FR_RXF = 1'b1;
    tick(4);
    n_assert++;
    if (n_writes - w0 != 7 || bridge_word - base != 32'd7) begin
      n_fail++;
      $display("FAIL rxf_total: got %0d writes %0d reads expected 7 and 7", n_writes - w0, bridge_word - base);
    end
  endtask

  task automatic test_full();
    int          w0;
    logic [31:0] base;
    w0     = n_writes;
    base   = bridge_word;
    FR_RXF = 1'b0;
    tick(6);
    dc32_fifo_is_full = 1'b1;
    tick();
    n_assert++;
    if (FT_RD !== 1'b1 || dut.cnt !== 2'd2 || write_to_dc32_fifo !== 1'b0) begin
      n_fail++;
      $display("FAIL full_backpressure: got RD=%b cnt=%0d wr=%b expected 1 2 0", FT_RD, dut.cnt, write_to_dc32_fifo);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_assert++;
      if (FT_RD !== 1'b1 || dc32_fifo_data_in !== base + 32'd3 || bridge_word - base != 32'd5) begin
        n_fail++;
        $display("FAIL full_hold%0d: got RD=%b data=%h reads=%0d expected 1 %h 5", i, FT_RD, dc32_fifo_data_in, bridge_word - base, base + 32'd3);
      end
    end
    dc32_fifo_is_full = 1'b0;
    tick(12);
    FR_RXF = 1'b1;
    tick(4);
    n_assert++;
    if (n_writes - w0 != int'(bridge_word - base) || bridge_word - base <= 32'd5 || dut.cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL full_resume: got %0d writes %0d reads cnt=%0d expected equal, more than 5, 0", n_writes - w0, bridge_word - base, dut.cnt);
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    FR_RXF = 1'b0;
    tick(6);
    @(posedge ftdi_clk);
    #3;
    reset_n = 1'b0;
    w0      = n_writes;
    #1;
    n_assert++;
    if ({FT_OE, FT_RD, write_to_dc32_fifo} !== 3'b110 || dut.cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got OE/RD/WR=%b%b%b cnt=%0d expected 110 0", FT_OE, FT_RD, write_to_dc32_fifo, dut.cnt);
    end
    @(posedge ftdi_clk);
    #3;
    FR_RXF  = 1'b1;
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge ftdi_clk);
      n_assert++;
      if (write_to_dc32_fifo !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_stale: got wr=%b expected 0", write_to_dc32_fifo);
      end
    end
    tick();
    n_assert++;
    if (n_writes != w0) begin
      n_fail++;
      $display("FAIL reset_mid_count: got %0d writes expected 0", n_writes - w0);
    end
  endtask

  task automatic test_random();
    int w0, p0;
    w0          = n_writes;
    p0          = n_pushes;
    bridge_word = $urandom;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 7) == 0)  FR_RXF            = ~FR_RXF;
      if ($urandom_range(0, 11) == 0) dc32_fifo_is_full = ~dc32_fifo_is_full;
      tick();
    end
    FR_RXF            = 1'b1;
    dc32_fifo_is_full = 1'b0;
    tick(6);
    n_assert++;
    if (n_writes - w0 != n_pushes - p0 || dut.cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL random_drain: got %0d writes for %0d reads cnt=%0d expected equal and 0", n_writes - w0, n_pushes - p0, dut.cnt);
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_rxf_stop();
    test_full();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/usb3_if_rx.md
# usb3_if_rx

Receive-side interface between an FTDI FT60x USB3 bridge in 245 synchronous-FIFO mode and the on-chip 32-bit dual-clock FIFO (dc32 FIFO). It runs entirely in the FTDI clock domain. It drives the bridge's active-low output-enable and read strobes, and captures one 32-bit word per clock while data is available. Captured words pass through a 2-entry skid buffer and are written into the dc32 FIFO, with back-pressure from its full flag.

## Interface
- DATA_W, 32, word width on both sides; only 32 is supported.
- ftdi_clk  in  1  FTDI 100 MHz clock; all logic uses its rising edge.
- reset_n  in  1  reset; asynchronous, active-low.
- FR_RXF  in  1  bridge RXF_N, active-low: 0 means the bridge has a word available.
- FT_OE  out  1  bridge OE_N, active-low; registered.
- FT_RD  out  1  bridge RD_N, active-low; registered.
- usb3_data_in  in  DATA_W  bridge data bus; valid at an edge where FR_RXF=0 and FT_RD=0.
- write_to_dc32_fifo  out  1  FIFO write enable, active-high; one word per cycle it is high.
- dc32_fifo_data_in  out  DATA_W  FIFO write data; equals the skid-buffer head.
- dc32_fifo_is_full  in  1  FIFO full flag, active-high, synchronous to ftdi_clk.

## Operation
- Skid buffer: 2 entries, FIFO order; occupancy cnt is 0..2.
  - Push at an edge where FT_RD=0 and FR_RXF=0, using the current registered FT_RD value. The pushed word is usb3_data_in.
  - Pop at an edge where write_to_dc32_fifo=1.
  - Push and pop may occur at the same edge; cnt is then unchanged.
- write_to_dc32_fifo = (cnt!=0) and not dc32_fifo_is_full. This is combinational from a registered count and an input.
- dc32_fifo_data_in = head entry; it holds its value while full is high.
- Let cnt_n be the occupancy after the current edge. The FSM uses three states:
  - IDLE: FT_OE=1, FT_RD=1. Go to TURN when FR_RXF=0 and cnt_n==0.
  - TURN (bus turnaround): FT_OE=0, FT_RD=1. Go to READ when FR_RXF=0 and cnt_n<=1. Go to IDLE when FR_RXF=1. Otherwise stay in TURN.
  - READ: FT_OE=0, FT_RD=0. Go to IDLE when FR_RXF=1 or cnt_n==2. Otherwise stay in READ.
- FT_OE and FT_RD are registered decodes of the next state.
- Words are never dropped or duplicated. cnt never exceeds 2.
- If FR_RXF is sampled 1 while FT_RD=0, nothing is pushed at that edge, and both strobes release at that edge.
- When dc32_fifo_is_full rises during READ:
  - at most one extra word is pushed;
  - FT_RD then releases;
  - reading resumes through IDLE→TURN once the buffer has drained.

## Timing
- Reset values: FSM in IDLE, FT_OE=1, FT_RD=1, cnt=0, write_to_dc32_fifo=0, dc32_fifo_data_in=0.
- A reset asserted mid-burst discards buffered words and releases both strobes immediately (asynchronously).
- From FR_RXF sampled low in IDLE:
  - FT_OE goes low after edge +1;
  - FT_RD goes low after edge +2;
  - the first push happens at edge +3.
- Capture to FIFO: a word pushed at edge t appears on dc32_fifo_data_in with the write enable after edge t. With an empty buffer and the FIFO not full, the FIFO takes it at edge t+1.
- Steady state: with the FIFO not full, throughput is 1 word per cycle and cnt=1.
- Back-pressure: if full is high at edge t+1, cnt reaches 2, FT_RD goes high after t+1, and no push occurs at t+2.

## Structure
- Shared package usb3_if_pkg holds:
  - the state enum (IDLE, TURN, READ);
  - SKID_DEPTH=2;
  - DATA_W.
- One sub-module, usb3_rx_skid: a 2-entry FIFO with push, pop, head, cnt and cnt_n outputs.
- The top level holds the FSM and the strobe registers.

## Test plan
- Reset: hold reset_n=0 with FR_RXF=0 -> FT_OE=1, FT_RD=1, write_to_dc32_fifo=0; no strobe activity until release.
- Burst of 8 words, 0x1000_0000..0x1000_0007, FIFO not full -> FT_OE low at +1 and FT_RD low at +2; 8 consecutive writes in order.
- FR_RXF high after word 3 of a burst -> only 3 writes; both strobes high after that edge; a later FR_RXF=0 restarts via TURN and the data continues in order.
- dc32_fifo_is_full high for 5 cycles mid-burst -> at most 2 words held, FT_RD released, no loss or duplication; the sequence resumes after full drops.
- Reset pulsed mid-burst -> cnt=0, strobes high; no write of pre-reset data.
- Random FR_RXF and full toggling over 10k cycles against a scoreboard -> exact in-order match; cnt<=2 at all times.
